// File: rtl/sync_edge_stamp_pkg.sv
// rtl/sync_edge_stamp_pkg.sv - shared edge-select codes and helpers for sync_edge_stamp
//
// Purpose:
//   Edge-select encodings used by the EDGE_SEL parameter of sync_edge_stamp,
//   plus a helper that decides whether a level transition is a selected edge.
// Contents:
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : EDGE_SEL codes
//   edge_selected(sel, new_level)      : 1 when a change to new_level is an event
package sync_edge_stamp_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // A change always flips the level, so the new level alone tells rise from fall.
  function automatic logic edge_selected(input int sel, input logic new_level);
    logic hit;
    case (sel)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      default:   hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// rtl/sync_glitch_filter.sv - N-sample persistence filter for a synchronised level
//
// Purpose:
//   Accepts a level change only after the input has differed from the current
//   filtered level for NFILT consecutive clocks. Shorter glitches are dropped.
// Ports:
//   clk    in   1  clock
//   rst_n  in   1  asynchronous active-low reset
//   in     in   1  synchronised level
//   level  out  1  filtered level (registered)
//   chg    out  1  high during the cycle whose clock edge flips level
module sync_glitch_filter
  import sync_edge_stamp_pkg::*;
#(
  parameter int   NFILT   = 4,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic chg
);

  localparam int             CW   = $clog2(NFILT + 1);
  localparam logic [CW-1:0]  LAST = CW'(NFILT - 1);

  logic [CW-1:0] count;

  // chg is decoded from the current state so the parent can register its
  // edge pulse on the very edge that updates level.
  assign chg = (in != level) && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= RST_LVL;
      count <= '0;
    end else if (in == level) begin
      count <= '0;
    end else if (chg) begin
      level <= in;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sync_edge_stamp.sv
// rtl/sync_edge_stamp.sv - filtered edge detector with timestamp, counter and event holding register
//
// Purpose:
//   Glitch-filters an already-synchronised level, detects the selected edge(s),
//   counts them and captures the system tick of each one into a single-entry
//   holding register read by the CPU with a valid/ack handshake. An event that
//   arrives while the register is still unread sets a sticky overrun flag and
//   is dropped (the oldest event is kept).
// Ports:
//   clk       in   1      clock
//   rst_n     in   1      asynchronous active-low reset
//   in_sync   in   1      synchronised level
//   ts        in   TS_W   free-running tick, sampled on accepted edges
//   level     out  1      filtered level
//   edge_p    out  1      one-cycle pulse per accepted selected edge
//   ev_valid  out  1      holding register contains an unread event
//   ev_ts     out  TS_W   timestamp of held event
//   ev_seq    out  CNT_W  edge_cnt value after held event
//   ev_ack    in   1      consumer has read the held event
//   edge_cnt  out  CNT_W  running count of accepted selected edges (wraps)
//   overrun   out  1      sticky: event lost because register was full
//   ovr_clr   in   1      clears overrun
module sync_edge_stamp
  import sync_edge_stamp_pkg::*;
#(
  parameter int   NFILT    = 4,
  parameter int   EDGE_SEL = EDGE_RISE,
  parameter int   TS_W     = 32,
  parameter int   CNT_W    = 16,
  parameter logic RST_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_sync,
  input  logic [TS_W-1:0]  ts,
  output logic             level,
  output logic             edge_p,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] ev_seq,
  input  logic             ev_ack,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic             chg;
  logic             accept;
  logic [CNT_W-1:0] cnt_next;

  sync_glitch_filter #(
    .NFILT   (NFILT),
    .RST_LVL (RST_LVL)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_sync),
    .level (level),
    .chg   (chg)
  );

  // On a change the new level is the inverse of the current one.
  assign accept   = chg && edge_selected(EDGE_SEL, ~level);
  assign cnt_next = edge_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_p   <= 1'b0;
      edge_cnt <= '0;
      ev_valid <= 1'b0;
      ev_ts    <= '0;
      ev_seq   <= '0;
      overrun  <= 1'b0;
    end else begin
      edge_p <= accept;

      if (accept) begin
        edge_cnt <= cnt_next;
      end

      // An ack in the same cycle frees the slot, so the new event still lands.
      if (accept && (!ev_valid || ev_ack)) begin
        ev_valid <= 1'b1;
        ev_ts    <= ts;
        ev_seq   <= cnt_next;
      end else if (ev_ack) begin
        ev_valid <= 1'b0;
      end

      // Setting has priority over clearing so a coincident loss is never hidden.
      if (accept && ev_valid && !ev_ack) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
